// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store bridge to a word-only, combinationally read memory.
// Optional MISALIGN_TRAP_EN rejects misaligned halfword/word accesses instead of truncating the address.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    output logic        mem_we,
    input  logic [31:0] mem_data_in
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

    state_t      state, next_state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [31:0] wdata_q;
    logic        mis_q;
    logic        req_mis;
    logic        req_sw;
    logic [31:0] shifted;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // funct3[1] set means word size (covers 010 and the 011/110/111 aliases)
    assign req_sw = req_we && req_funct3[1];

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        req_mis = 1'b0;
        if (req_funct3[1])
            req_mis = (req_addr[1:0] != 2'b00);
        else if (req_funct3[0])
            req_mis = req_addr[0];
    end
`else
    always_comb begin
        req_mis = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (req_mis)     next_state = DONE;
                    else if (req_sw) next_state = WRITE;
                    else             next_state = ACCESS;
                end
            end
            ACCESS:  next_state = we_q ? WRITE : DONE;
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        shifted  = mem_data_in >> {lo_q, 3'b000};
        half_sel = lo_q[1] ? mem_data_in[31:16] : mem_data_in[15:0];
        case (f3_q[1:0])
            2'b00:   load_val = f3_q[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = f3_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_data_in;
        endcase
        merged = mem_data_in;
        if (f3_q[1:0] == 2'b00)
            merged[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
        else if (f3_q[1:0] == 2'b01)
            merged[{lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merged = wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            lo_q         <= 2'd0;
            wdata_q      <= 32'd0;
            mis_q        <= 1'b0;
            rdata        <= 32'd0;
            mem_address  <= 32'd0;
            mem_data_out <= 32'd0;
            mem_we       <= 1'b0;
        end else begin
            mem_we <= (next_state == WRITE);
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        lo_q    <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        mis_q   <= req_mis;
                        if (!req_mis) begin
                            mem_address <= {req_addr[31:2], 2'b00};
                            if (req_sw) mem_data_out <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) mem_data_out <= merged;
                    else      rdata        <= load_val;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign misaligned = done && mis_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential bridge between the processor core's load/store path and the word-only, combinationally read data memory. It turns byte, halfword and word loads/stores into aligned 32-bit memory accesses, and performs sub-word stores as a registered read-modify-write. Sits directly upstream of the memory: it owns the memory's address, write-data and write-enable inputs and consumes its read data.

## Interface

Parameters: none.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  core access request (level; sampled only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low byte/halfword used for SB/SH
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle completion pulse
- rdata  output  32  load result; valid with done, held until next load completes
- misaligned  output  1  pulses with done on a rejected misaligned access (see Configuration)
- mem_address  output  32  to memory address; always word-aligned ([1:0] = 00)
- mem_data_out  output  32  to memory data_in
- mem_we  output  1  to memory we
- mem_data_in  input  32  from memory data_out (combinational read)

## Operation

- Little-endian lanes: byte k = bits [8k+7:8k]; halfword h = bits [16h+15:16h].
- FSM states: IDLE, ACCESS, WRITE, DONE.
- IDLE: on req=1, latch req_we, req_funct3, req_addr, req_wdata; drive mem_address = {req_addr[31:2],2'b00}. Next: load → ACCESS; SW → WRITE; SB/SH → ACCESS.
- ACCESS: mem_we=0; capture mem_data_in into a word register. Load → DONE with extracted, sign-/zero-extended rdata registered. Sub-word store → WRITE.
- WRITE: mem_we=1 for exactly this cycle; mem_data_out = captured word with the addressed lane(s) replaced (SW: req_wdata whole). → DONE.
- DONE: done=1; → IDLE. A new req is accepted only in IDLE, i.e. the cycle after DONE at the earliest.
- req while busy is ignored; latched fields never change mid-operation.
- Load funct3 011/110/111 are treated as LW; for stores funct3[2] is ignored.
- mem_address, mem_data_out, mem_we are register outputs (no combinational glitches into the memory); mem_data_out changes only when entering WRITE.

## Timing

- Request accepted at edge ending cycle N (state IDLE, req=1).
- Load: ACCESS in N+1, done in N+2.
- SW: WRITE in N+1, done in N+2 (no read).
- SB/SH: ACCESS in N+1, WRITE in N+2, done in N+3.
- Reset (any time, including mid-WRITE): state=IDLE immediately; busy, done, misaligned, mem_we = 0; rdata, mem_address, mem_data_out = 0. A store interrupted before WRITE never writes memory.

## Configuration

- MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]≠00 is rejected in IDLE → DONE in N+1 with done=1 and misaligned=1; no memory access, mem_we stays 0, rdata unchanged.
- Undefined: misaligned tied to 0; low address bits silently dropped (halfword uses addr[1] only, word ignores addr[1:0]); access proceeds normally.

## Test plan

- Memory word 0x800 = 0x8899AABB; LB 0x801 → rdata 0xFFFFFFAA, done at N+2; LBU 0x801 → 0x000000AA; LH 0x802 → 0xFFFF8899.
- SH 0x802, wdata 0x00001234 → mem_we high exactly in N+2, word 0x800 becomes 0x1234AABB, done at N+3, rdata unchanged.
- SW 0x800, wdata 0xDEADBEEF → no ACCESS state, mem_we in N+1, done in N+2; subsequent LW 0x800 → 0xDEADBEEF.
- SB 0x803, wdata 0x55, reset asserted during ACCESS → mem_we never asserted, word stays 0x8899AABB, all outputs 0.
- req held high through a load → second request accepted only in cycle after done; done pulses once per access.
- LW 0x802: with MISALIGN_TRAP_EN → done+misaligned in N+1, no mem_we; without → rdata = word at 0x800, misaligned=0.
